// File: rtl/sm_fetch_unit.sv
// rtl/sm_fetch_unit.sv - round-robin warp instruction fetch unit; optional PC redirect under FETCH_REDIRECT_EN
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 32
`endif
`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 16
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif

module sm_fetch_unit #(
  parameter int NUM_WARP   = `NUM_WARP,
  parameter int DEPTH_WARP = `DEPTH_WARP,
  parameter int PC_W       = `CODE_ADDR_WIDTH,
  parameter int MADDR_W    = `CODE_MEM_ADDR_WIDTH,
  parameter int INST_W     = `CODE_MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sm_warp_req_valid_i,
  input  logic [DEPTH_WARP-1:0] sm_warp_req_wid_i,
  input  logic [PC_W-1:0]       sm_warp_req_start_addr_i,
  input  logic [NUM_WARP-1:0]   inst_buffer_avail_i,
  input  logic                  warp_exit_valid_i,
  input  logic [DEPTH_WARP-1:0] warp_exit_wid_i,
`ifdef FETCH_REDIRECT_EN
  input  logic                  redirect_valid_i,
  input  logic [DEPTH_WARP-1:0] redirect_wid_i,
  input  logic [PC_W-1:0]       redirect_pc_i,
`endif
  input  logic                  code_mem_available_i,
  output logic                  code_read_valid_o,
  output logic [MADDR_W-1:0]    code_read_addr_o,
  output logic [DEPTH_WARP-1:0] code_read_wid_o,
  input  logic                  code_read_ready_i,
  input  logic [INST_W-1:0]     code_read_data_i,
  output logic                  fetch_valid_o,
  output logic [DEPTH_WARP-1:0] fetch_wid_o,
  output logic [PC_W-1:0]       fetch_pc_o,
  output logic [INST_W-1:0]     fetch_inst_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [NUM_WARP-1:0]   active;
  logic [PC_W-1:0]       pc [NUM_WARP];
  logic [DEPTH_WARP-1:0] rr_ptr;
  logic [DEPTH_WARP-1:0] cur_wid;
  logic [PC_W-1:0]       cur_pc;
  logic [INST_W-1:0]     cur_inst;
  logic                  squash;

  logic                  rd_valid;
  logic [DEPTH_WARP-1:0] rd_wid;
  logic [PC_W-1:0]       rd_pc;

`ifdef FETCH_REDIRECT_EN
  assign rd_valid = redirect_valid_i;
  assign rd_wid   = redirect_wid_i;
  assign rd_pc    = redirect_pc_i;
`else
  assign rd_valid = 1'b0;
  assign rd_wid   = '0;
  assign rd_pc    = '0;
`endif

  logic [NUM_WARP-1:0]   elig;
  logic                  any_elig;
  logic [DEPTH_WARP-1:0] pick;
  int                    idx;
  logic                  hit_cur;
  logic                  squash_now;
  logic                  do_inc;

  // A warp whose PC/active bit is changing this cycle is skipped so a stale PC is never latched
  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      elig[w] = active[w] & inst_buffer_avail_i[w]
              & ~(sm_warp_req_valid_i && sm_warp_req_wid_i == DEPTH_WARP'(w))
              & ~(warp_exit_valid_i && warp_exit_wid_i == DEPTH_WARP'(w))
              & ~(rd_valid && rd_wid == DEPTH_WARP'(w));
    end
  end

  // Round-robin search starting one past the last granted warp
  always_comb begin
    any_elig = 1'b0;
    pick     = rr_ptr;
    idx      = 0;
    for (int i = 1; i <= NUM_WARP; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_WARP;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        pick     = DEPTH_WARP'(idx);
      end
    end
  end

  // Any launch/exit/redirect touching the in-flight warp kills its result
  always_comb begin
    hit_cur    = (sm_warp_req_valid_i && sm_warp_req_wid_i == cur_wid)
               || (warp_exit_valid_i && warp_exit_wid_i == cur_wid)
               || (rd_valid && rd_wid == cur_wid);
    squash_now = squash | (((state == S_REQ) || (state == S_WAIT)) & hit_cur);
    do_inc     = (state == S_WAIT) && code_read_ready_i && !squash_now;
  end

  // Per-warp active bit and PC: launch beats redirect beats increment; launch beats exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      for (int w = 0; w < NUM_WARP; w++) pc[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        if (sm_warp_req_valid_i && sm_warp_req_wid_i == DEPTH_WARP'(w)) begin
          active[w] <= 1'b1;
          pc[w]     <= sm_warp_req_start_addr_i;
        end else begin
          if (warp_exit_valid_i && warp_exit_wid_i == DEPTH_WARP'(w)) active[w] <= 1'b0;
          if (rd_valid && rd_wid == DEPTH_WARP'(w)) pc[w] <= rd_pc;
          else if (do_inc && cur_wid == DEPTH_WARP'(w)) pc[w] <= pc[w] + PC_W'(4);
        end
      end
    end
  end

  // Single-outstanding fetch sequencer: select, request, await response, present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= DEPTH_WARP'(NUM_WARP - 1);
      cur_wid  <= '0;
      cur_pc   <= '0;
      cur_inst <= '0;
      squash   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            cur_wid <= pick;
            cur_pc  <= pc[pick];
            rr_ptr  <= pick;
            squash  <= 1'b0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          squash <= squash_now;
          if (code_mem_available_i) state <= S_WAIT;
        end
        S_WAIT: begin
          squash <= squash_now;
          if (code_read_ready_i) begin
            cur_inst <= code_read_data_i;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign code_read_valid_o = (state == S_REQ);
  assign code_read_addr_o  = code_read_valid_o ? cur_pc[MADDR_W+1:2] : '0;
  assign code_read_wid_o   = code_read_valid_o ? cur_wid : '0;
  assign fetch_valid_o     = (state == S_DONE) && !squash;
  assign fetch_wid_o       = fetch_valid_o ? cur_wid : '0;
  assign fetch_pc_o        = fetch_valid_o ? cur_pc : '0;
  assign fetch_inst_o      = fetch_valid_o ? cur_inst : '0;

endmodule

// File: doc/sm_fetch_unit.md
SM_FETCH_UNIT -- requirements
Module: sm_fetch_unit

Interface
REQ-001 Parameters SHALL be: NUM_WARP, default `NUM_WARP (8), warp slots; DEPTH_WARP, default `DEPTH_WARP (3), warp-id width; PC_W, default `CODE_ADDR_WIDTH (32), byte PC width; MADDR_W, default `CODE_MEM_ADDR_WIDTH (16), word address width; INST_W, default `CODE_MEM_DATA_WIDTH (32), instruction width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sm_warp_req_valid_i  input  1  launch pulse from warp assign.
REQ-005 sm_warp_req_wid_i  input  DEPTH_WARP  warp being launched.
REQ-006 sm_warp_req_start_addr_i  input  PC_W  kernel start byte address.
REQ-007 inst_buffer_avail_i  input  NUM_WARP  per-warp instruction buffer has a free entry.
REQ-008 warp_exit_valid_i / warp_exit_wid_i  input  1 / DEPTH_WARP  warp retired; stop fetching it.
REQ-009 code_mem_available_i  input  1  code memory accepts a read this cycle.
REQ-010 code_read_valid_o / code_read_addr_o / code_read_wid_o  output  1 / MADDR_W / DEPTH_WARP  read request.
REQ-011 code_read_ready_i / code_read_data_i  input  1 / INST_W  read response.
REQ-012 fetch_valid_o / fetch_wid_o / fetch_pc_o / fetch_inst_o  output  1 / DEPTH_WARP / PC_W / INST_W  fetched instruction to decode.

Function
REQ-013 Per-warp state SHALL be: active bit, PC (PC_W).
REQ-014 Launch SHALL set active[wid]=1 and pc[wid]=start_addr on the cycle after sm_warp_req_valid_i.
REQ-015 Exit SHALL clear active[wid] on the cycle after warp_exit_valid_i.
REQ-016 Warp eligible = active & inst_buffer_avail_i[w] & not pending-launch/exit this cycle.
REQ-017 Selection SHALL be round-robin, starting at the warp after the last granted one; pointer resets to NUM_WARP-1 so warp 0 wins first.
REQ-018 FSM states: IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: if any eligible warp, latch wid and PC, go to REQ next cycle.
REQ-020 REQ: code_read_valid_o=1, addr=pc[MADDR_W+1:2], wid=latched wid, held stable; accepted when code_mem_available_i=1, then go WAIT.
REQ-021 WAIT: on code_read_ready_i, capture data, pc[wid]+=4 (mod 2^PC_W wrap), go DONE.
REQ-022 DONE: fetch_valid_o=1 for exactly one cycle with wid, PC of the fetched instruction, data; return to IDLE.
REQ-023 Only one request SHALL be outstanding; minimum 4 cycles per instruction with zero-wait memory.
REQ-024 Exit or relaunch of the in-flight warp during REQ/WAIT SHALL squash: response still awaited, but PC not incremented and fetch_valid_o suppressed.
REQ-025 Launch and exit of the same wid in one cycle: launch wins.
REQ-026 code_read_ready_i outside WAIT SHALL be ignored.
REQ-027 inst_buffer_avail_i falling after selection SHALL NOT cancel the in-flight fetch.

Reset
REQ-028 rst_n low SHALL immediately clear all active bits, PCs to 0, FSM to IDLE, RR pointer to NUM_WARP-1, all outputs to 0; in-flight request abandoned, late response ignored.

Configuration
REQ-029 Macro FETCH_REDIRECT_EN: when defined, ports redirect_valid_i (1), redirect_wid_i (DEPTH_WARP), redirect_pc_i (PC_W) SHALL exist; redirect sets pc[wid] next cycle, squashes an in-flight fetch of that wid per REQ-024, priority below launch, above increment; when undefined, ports absent, PC changes only by launch and increment.

Verification
REQ-030 Launch wid 2 at 0x100, all avail, memory instant -> reads at addr 0x40,0x41,0x42; fetch_pc_o 0x100,0x104,0x108, wid 2.
REQ-031 Launch wids 0,1,3 -> fetch order 0,1,3,0,1,3 (round-robin).
REQ-032 Hold code_mem_available_i low 5 cycles in REQ -> code_read_valid_o/addr/wid stable; one read issued after.
REQ-033 Exit wid 1 while in WAIT -> no fetch_valid_o for that response; pc[1] unchanged; next fetch is another warp.
REQ-034 inst_buffer_avail_i[0]=0 with only warp 0 active -> no read issued; raise -> read next cycle+1.
REQ-035 Assert rst_n low during WAIT, response arrives after release -> no fetch_valid_o, all outputs 0, no warp active.
